parallax_layer_engine: RTL and testbench

// - Parametrised N-layer parallax checkerboard renderer for the TinyVGA output path; the layer count is set at build time.
// - Sits between hvsync_generator (pix_x/pix_y/display_on/syncs) and the uo_out PMOD mapping.
// - Additions in this generation:
//   - clk-domain frame stepping;
//   - per-layer runtime speed registers;
//   - pause and reverse modes;
//   - registered 2-stage output with sync signals delay-matched.

---
 rtl/parallax_pkg.sv | 36 +++
 rtl/parallax_layer.sv | 82 ++++++++
 rtl/parallax_layer_engine.sv | 129 ++++++++++++
 tb/tb_parallax_layer_engine.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parallax_pkg.sv
// rtl/parallax_pkg.sv - shared constants and colour helper for the parallax layer engine
//
// Purpose : offset width, colour derivation constants and the per-layer
//           colour function used by the output priority mux.
// Ports   : none (package).

package parallax_pkg;

  localparam int OFF_W = 10;

  localparam logic [5:0] COL_MASK_10 = 6'b10_10_10;
  localparam logic [5:0] COL_XOR_1   = 6'b00_10_10;

  // Layer colours derive from base_color so one input retints the whole scene:
  // c0 = ~base, c1 = c0 ^ XOR, c2 = c1 & MASK, every deeper layer = c2 >> 1.
  function automatic logic [5:0] layer_colour(input int layer, input logic [5:0] base);
    logic [5:0] c0;
    logic [5:0] c1;
    logic [5:0] c2;
    logic [5:0] result;
    c0 = ~base;
    c1 = c0 ^ COL_XOR_1;
    c2 = c1 & COL_MASK_10;
    if (layer == 0) begin
      result = c0;
    end else if (layer == 1) begin
      result = c1;
    end else if (layer == 2) begin
      result = c2;
    end else begin
      result = c2 >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/parallax_layer.sv
// rtl/parallax_layer.sv - one scrolling checkerboard layer: speed regs, offsets, hit test
//
// Purpose : holds this layer's x/y speed and x/y scroll offset, steps the
//           offsets once per frame and produces a combinational checker hit
//           for the current pixel.
// Ports   : clk, rst_n      - pixel clock, synchronous active-low reset
//           step            - advance/retreat offsets this cycle
//           dir             - 0 = add speed, 1 = subtract speed
//           wr_en           - load wr_sx/wr_sy into the speed registers
//           wr_sx, wr_sy    - new speeds
//           pix_x, pix_y    - current pixel
//           hit             - layer covers this pixel (combinational)

module parallax_layer
  import parallax_pkg::*;
#(
  parameter int SPD_W    = 4,
  parameter int TILE_BIT = 8,
  parameter bit DITHER   = 1'b0,
  parameter int RST_SX   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             dir,
  input  logic             wr_en,
  input  logic [SPD_W-1:0] wr_sx,
  input  logic [SPD_W-1:0] wr_sy,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  output logic             hit
);

  localparam logic [SPD_W-1:0] RST_SX_V = RST_SX[SPD_W-1:0];
  localparam logic [SPD_W-1:0] RST_SY_V = {{(SPD_W-1){1'b0}}, 1'b1};

  logic [SPD_W-1:0] sx;
  logic [SPD_W-1:0] sy;
  logic [OFF_W-1:0] off_x;
  logic [OFF_W-1:0] off_y;

  logic [OFF_W-1:0] sx_ext;
  logic [OFF_W-1:0] sy_ext;
  assign sx_ext = OFF_W'(sx);
  assign sy_ext = OFF_W'(sy);

  // Offsets wrap modulo 1024 in both directions through natural 10-bit overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      off_x <= '0;
      off_y <= '0;
      sx    <= RST_SX_V;
      sy    <= RST_SY_V;
    end else begin
      if (step) begin
        off_x <= dir ? (off_x - sx_ext) : (off_x + sx_ext);
        off_y <= dir ? (off_y - sy_ext) : (off_y + sy_ext);
      end
      if (wr_en) begin
        sx <= wr_sx;
        sy <= wr_sy;
      end
    end
  end

  logic [OFF_W-1:0] lx;
  logic [OFF_W-1:0] ly;
  logic             tile;
  logic             dither_on;

  assign lx        = pix_x + off_x;
  assign ly        = pix_y + off_y;
  assign tile      = lx[TILE_BIT] ^ ly[TILE_BIT];
  // Dithered layers become see-through on a fixed 2x2-ish pixel pattern.
  assign dither_on = pix_y[1] ^ pix_x[0];
  assign hit       = tile & (DITHER ? dither_on : 1'b1);

  // Only one bit of each shifted coordinate selects the tile; the rest is carry chain.
  logic unused_lxy;
  assign unused_lxy = ^{lx, ly};

endmodule

// File: rtl/parallax_layer_engine.sv
// rtl/parallax_layer_engine.sv - N-layer parallax checkerboard renderer with 2-stage output
//
// Purpose : renders NUM_LAYERS scrolling checkerboards with per-layer speed,
//           pause/reverse, and a priority mux (layer 0 in front). Output and
//           syncs are both delayed exactly 2 clocks so they stay aligned.
// Ports   : clk, rst_n                - pixel clock, synchronous active-low reset
//           frame_tick                - once-per-frame step pulse
//           pix_x, pix_y, video_active- beam position and display enable
//           hsync_in, vsync_in        - raw syncs
//           pause, dir                - freeze / reverse scrolling
//           base_color                - scene tint, layer 0 = ~base_color
//           cfg_valid, cfg_ready      - speed write handshake
//           cfg_layer, cfg_sx, cfg_sy - speed write target and values
//           rgb, hsync_out, vsync_out - pipelined video out

module parallax_layer_engine
  import parallax_pkg::*;
#(
  parameter int         NUM_LAYERS  = 5,
  parameter int         TILE_MSB    = 8,
  parameter int         SPD_W       = 4,
  parameter logic [7:0] DITHER_MASK = 8'b0001_0011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             video_active,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             pause,
  input  logic             dir,
  input  logic [5:0]       base_color,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_layer,
  input  logic [SPD_W-1:0] cfg_sx,
  input  logic [SPD_W-1:0] cfg_sy,
  output logic [5:0]       rgb,
  output logic             hsync_out,
  output logic             vsync_out
);

  generate
    if (NUM_LAYERS < 2 || NUM_LAYERS > 8 || TILE_MSB < NUM_LAYERS - 1 || TILE_MSB > 9) begin : g_bad_cfg
      $error("parallax_layer_engine: NUM_LAYERS/TILE_MSB out of range");
    end
  endgenerate

  // Blocking writes on tick cycles keeps a speed change from racing an offset step.
  assign cfg_ready = !frame_tick;

  logic step;
  logic cfg_fire;
  assign step     = frame_tick & !pause;
  assign cfg_fire = cfg_valid & cfg_ready;

  logic [NUM_LAYERS-1:0] hit;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    logic wr_en;
    // Out-of-range layer indices match no layer, so the write is silently dropped.
    assign wr_en = cfg_fire && (cfg_layer == 3'(i));

    parallax_layer #(
      .SPD_W    (SPD_W),
      .TILE_BIT (TILE_MSB - i),
      .DITHER   (DITHER_MASK[i]),
      .RST_SX   (NUM_LAYERS - i)
    ) u_layer (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (step),
      .dir   (dir),
      .wr_en (wr_en),
      .wr_sx (cfg_sx),
      .wr_sy (cfg_sy),
      .pix_x (pix_x),
      .pix_y (pix_y),
      .hit   (hit[i])
    );
  end

  // Stage 1: capture hit vector with the control signals it belongs to.
  logic [NUM_LAYERS-1:0] hit_s1;
  logic                  act_s1;
  logic                  hs_s1;
  logic                  vs_s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_s1 <= '0;
      act_s1 <= 1'b0;
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
    end else begin
      hit_s1 <= hit;
      act_s1 <= video_active;
      hs_s1  <= hsync_in;
      vs_s1  <= vsync_in;
    end
  end

  // Priority mux: scanning from the back lets the front-most hit win.
  logic [5:0] colour;
  always_comb begin
    colour = 6'd0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        colour = layer_colour(i, base_color);
      end
    end
  end

  // Stage 2: blank outside active video and realign syncs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb       <= 6'd0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb       <= act_s1 ? colour : 6'd0;
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
    end
  end

endmodule

// File: tb/tb_parallax_layer_engine.sv
// tb/tb_parallax_layer_engine.sv - self-checking bench for parallax_layer_engine

module tb_parallax_layer_engine;

  localparam int NL = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_active;
  logic       hsync_in;
  logic       vsync_in;
  logic       pause;
  logic       dir;
  logic [5:0] base_color;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_layer;
  logic [3:0] cfg_sx;
  logic [3:0] cfg_sy;
  logic [5:0] rgb;
  logic       hsync_out;
  logic       vsync_out;

  always #5 clk = ~clk;

  parallax_layer_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .video_active (video_active),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .pause        (pause),
    .dir          (dir),
    .base_color   (base_color),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_layer    (cfg_layer),
    .cfg_sx       (cfg_sx),
    .cfg_sy       (cfg_sy),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out)
  );

  logic [9:0] dox [NL];
  logic [9:0] doy [NL];
  for (genvar g = 0; g < NL; g++) begin : g_tap
    assign dox[g] = dut.g_layer[g].u_layer.off_x;
    assign doy[g] = dut.g_layer[g].u_layer.off_y;
  end

  int nvec = 0;
  int nerr = 0;

  // Reference model state.
  int         mox [NL];
  int         moy [NL];
  int         msx [NL];
  int         msy [NL];
  logic [4:0] m_hit;
  logic       m_act;
  logic       m_hs;
  logic       m_vs;
  logic [5:0] e_rgb;
  logic       e_hs;
  logic       e_vs;

  function automatic logic [5:0] ref_colour(int layer, logic [5:0] base);
    logic [5:0] c0;
    logic [5:0] c1;
    logic [5:0] c2;
    c0 = ~base;
    c1 = c0 ^ 6'b001010;
    c2 = c1 & 6'b101010;
    if (layer == 0) return c0;
    if (layer == 1) return c1;
    if (layer == 2) return c2;
    return {1'b0, c2[5:1]};
  endfunction

  function automatic logic [4:0] ref_hits(int px, int py);
    logic [4:0] h;
    int dmask;
    dmask = 'b10011;
    for (int i = 0; i < NL; i++) begin
      int b;
      int lx;
      int ly;
      int t;
      int d;
      b  = 8 - i;
      lx = (px + mox[i]) % 1024;
      ly = (py + moy[i]) % 1024;
      t  = ((lx >> b) & 1) ^ ((ly >> b) & 1);
      d  = ((py >> 1) & 1) ^ (px & 1);
      h[i] = (t == 1) && ((((dmask >> i) & 1) == 0) || d == 1);
    end
    return h;
  endfunction

  function automatic logic [5:0] ref_pick(logic [4:0] h, logic [5:0] base);
    for (int i = 0; i < NL; i++) begin
      if (h[i]) return ref_colour(i, base);
    end
    return 6'd0;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin
        mox[i] = 0;
        moy[i] = 0;
        msx[i] = NL - i;
        msy[i] = 1;
      end
      m_hit = '0; m_act = 0; m_hs = 0; m_vs = 0;
      e_rgb = '0; e_hs = 0; e_vs = 0;
    end else begin
      e_rgb = m_act ? ref_pick(m_hit, base_color) : 6'd0;
      e_hs  = m_hs;
      e_vs  = m_vs;
      m_hit = ref_hits(int'(pix_x), int'(pix_y));
      m_act = video_active;
      m_hs  = hsync_in;
      m_vs  = vsync_in;
      if (frame_tick && !pause) begin
        for (int i = 0; i < NL; i++) begin
          if (dir) begin
            mox[i] = (mox[i] + 1024 - msx[i]) % 1024;
            moy[i] = (moy[i] + 1024 - msy[i]) % 1024;
          end else begin
            mox[i] = (mox[i] + msx[i]) % 1024;
            moy[i] = (moy[i] + msy[i]) % 1024;
          end
        end
      end
      if (cfg_valid && !frame_tick && int'(cfg_layer) < NL) begin
        msx[int'(cfg_layer)] = int'(cfg_sx);
        msy[int'(cfg_layer)] = int'(cfg_sy);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(string nm, int got, int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic chk_model(string nm);
    chk({nm, ".rgb"}, int'(rgb), int'(e_rgb));
    chk({nm, ".hsync"}, int'(hsync_out), int'(e_hs));
    chk({nm, ".vsync"}, int'(vsync_out), int'(e_vs));
  endtask

  task automatic chk_offsets(string nm);
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("%s.off_x[%0d]", nm, i), int'(dox[i]), mox[i]);
      chk($sformatf("%s.off_y[%0d]", nm, i), int'(doy[i]), moy[i]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       act;
    logic [5:0] base;
    logic [5:0] exp;
  } vec_t;

  vec_t vt [12];

  int exp_x3 [NL];
  int hs_high;

  initial begin
    vt[0]  = '{10'd0,   10'd256, 1'b1, 6'h00, 6'h00};
    vt[1]  = '{10'd1,   10'd256, 1'b1, 6'h00, 6'h3F};
    vt[2]  = '{10'd1,   10'd256, 1'b0, 6'h00, 6'h00};
    vt[3]  = '{10'd1,   10'd128, 1'b1, 6'h00, 6'h35};
    vt[4]  = '{10'd0,   10'd64,  1'b1, 6'h00, 6'h20};
    vt[5]  = '{10'd16,  10'd0,   1'b1, 6'h00, 6'h00};
    vt[6]  = '{10'd17,  10'd0,   1'b1, 6'h00, 6'h10};
    vt[7]  = '{10'd32,  10'd0,   1'b1, 6'h00, 6'h10};
    vt[8]  = '{10'd1,   10'd256, 1'b1, 6'h2A, 6'h15};
    vt[9]  = '{10'd1,   10'd128, 1'b1, 6'h2A, 6'h1F};
    vt[10] = '{10'd0,   10'd64,  1'b1, 6'h2A, 6'h0A};
    vt[11] = '{10'd256, 10'd256, 1'b1, 6'h00, 6'h00};
    exp_x3 = '{15, 12, 9, 6, 3};

    rst_n = 1'b0; frame_tick = 0; pix_x = 0; pix_y = 0; video_active = 1;
    hsync_in = 1; vsync_in = 1; pause = 0; dir = 0; base_color = 0;
    cfg_valid = 0; cfg_layer = 0; cfg_sx = 0; cfg_sy = 0;

    // Reset state
    cyc();
    cyc();
    chk("reset.rgb", int'(rgb), 0);
    chk("reset.hsync", int'(hsync_out), 0);
    chk("reset.vsync", int'(vsync_out), 0);
    rst_n = 1'b1;
    hsync_in = 0; vsync_in = 0;
    cyc();
    chk("reset.cfg_ready", int'(cfg_ready), 1);
    chk_offsets("reset");

    // Three forward steps
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("fwd3.off_x[%0d]", i), int'(dox[i]), exp_x3[i]);
      chk($sformatf("fwd3.off_y[%0d]", i), int'(doy[i]), 3);
    end

    // Reverse wrap
    do_reset();
    dir = 1;
    tick();
    chk("rev.off_x[0]", int'(dox[0]), 1019);
    for (int i = 0; i < NL; i++) chk($sformatf("rev.off_y[%0d]", i), int'(doy[i]), 1023);
    dir = 0;

    // Pause holds offsets and the image
    do_reset();
    tick();
    tick();
    pix_x = 10'd37; pix_y = 10'd250; video_active = 1; base_color = 6'h0C;
    pause = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int i = 0; i < NL; i++) begin
        chk($sformatf("pause.off_x[%0d]", i), int'(dox[i]), 2 * (NL - i));
        chk($sformatf("pause.off_y[%0d]", i), int'(doy[i]), 2);
      end
      chk_model("pause");
    end
    pause = 0;

    // Config handshake
    do_reset();
    cfg_valid = 1; cfg_layer = 3'd2; cfg_sx = 4'd7; cfg_sy = 4'd0;
    frame_tick = 1;
    #1;
    chk("cfg.ready_on_tick", int'(cfg_ready), 0);
    cyc();
    frame_tick = 0;
    #1;
    chk("cfg.ready_after_tick", int'(cfg_ready), 1);
    chk("cfg.tick_old_speed_x", int'(dox[2]), 3);
    cyc();
    cfg_valid = 0;
    tick();
    chk("cfg.new_speed_x", int'(dox[2]), 10);
    chk("cfg.new_speed_y", int'(doy[2]), 1);
    cfg_valid = 1; cfg_layer = 3'd6; cfg_sx = 4'd15; cfg_sy = 4'd15;
    cyc();
    cfg_valid = 0;
    tick();
    chk("cfg.drop.off_x[0]", int'(dox[0]), 15);
    chk("cfg.drop.off_x[1]", int'(dox[1]), 12);
    chk("cfg.drop.off_x[2]", int'(dox[2]), 17);
    chk("cfg.drop.off_x[3]", int'(dox[3]), 6);
    chk("cfg.drop.off_x[4]", int'(dox[4]), 3);
    chk("cfg.drop.off_y[2]", int'(doy[2]), 1);
    chk("cfg.drop.off_y[4]", int'(doy[4]), 3);

    // Colour table at zero offsets
    do_reset();
    foreach (vt[v]) begin
      pix_x = vt[v].px; pix_y = vt[v].py; video_active = vt[v].act; base_color = vt[v].base;
      cyc();
      cyc();
      chk($sformatf("table[%0d].rgb", v), int'(rgb), int'(vt[v].exp));
    end

    // Exact 2-clock latency
    pix_x = 0; pix_y = 0; video_active = 1; base_color = 0;
    cyc();
    cyc();
    pix_x = 10'd1; pix_y = 10'd256;
    cyc();
    chk("latency.edge1", int'(rgb), 0);
    cyc();
    chk("latency.edge2", int'(rgb), 'h3F);

    // 96-clock hsync pulse
    hs_high = 0;
    for (int k = 0; k < 110; k++) begin
      hsync_in = (k >= 2 && k < 98);
      cyc();
      chk($sformatf("hsync.k%0d", k), int'(hsync_out), ((k - 1) >= 2 && (k - 1) < 98) ? 1 : 0);
      if (hsync_out) hs_high++;
    end
    chk("hsync.width", hs_high, 96);

    // Reset mid-line
    pix_x = 10'd1; pix_y = 10'd256; video_active = 1; hsync_in = 1; vsync_in = 1;
    cyc(); cyc(); cyc();
    chk("midrst.pre_rgb", int'(rgb), 'h3F);
    rst_n = 0;
    cyc();
    chk("midrst.rgb", int'(rgb), 0);
    chk("midrst.hsync", int'(hsync_out), 0);
    chk("midrst.vsync", int'(vsync_out), 0);
    rst_n = 1;
    hsync_in = 0; vsync_in = 0;
    cyc();

    // Randomized run against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst_n        = ($urandom_range(0, 599) != 0);
      frame_tick   = ($urandom_range(0, 24) == 0);
      pause        = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) dir = ~dir;
      cfg_valid    = ($urandom_range(0, 5) == 0);
      cfg_layer    = 3'($urandom_range(0, 7));
      cfg_sx       = 4'($urandom);
      cfg_sy       = 4'($urandom);
      pix_x        = 10'($urandom);
      pix_y        = 10'($urandom);
      video_active = ($urandom_range(0, 3) != 0);
      hsync_in     = 1'($urandom);
      vsync_in     = 1'($urandom);
      base_color   = 6'($urandom);
      cyc();
      chk_model("rand");
      if (k % 64 == 63) chk_offsets("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
